// File: rtl/prga_streamer_pkg.sv
// Shared types and helpers for the PRGA bitstream streamer.
package prga_streamer_pkg;

   // Streamer sequencing states; every transition except LOAD capture
   // happens on a programming-clock fall tick.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      LOAD   = 3'd2,
      SHIFT  = 3'd3,
      FINISH = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_e;

   // Bit counter must hold the value WORD_WIDTH itself, hence the +1.
   function automatic int bit_cnt_width(input int word_width);
      return $clog2(word_width) + 1;
   endfunction

   localparam int WORD_WIDTH_DEF = 32;
   localparam int BIT_CNT_W      = bit_cnt_width(WORD_WIDTH_DEF);

   // Saturating increment for the 32-bit status counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/prga_prog_clkdiv.sv
// Programming clock divider: free-running counter that toggles prog_clk on
// wrap and flags the tb_clk edges on which prog_clk falls or rises.
module prga_prog_clkdiv #(
   parameter int CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_prog_clk,
   output logic o_fall_tick,
   output logic o_rise_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_prog_clk;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));

   // Half-period counter; prog_clk flips each time it wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_prog_clk <= 1'b0;
      end else if (w_wrap) begin
         r_cnt      <= '0;
         r_prog_clk <= ~r_prog_clk;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_prog_clk  = r_prog_clk;
   // Asserted during the cycle whose closing edge moves prog_clk 1->0 / 0->1.
   assign o_fall_tick = w_wrap &  r_prog_clk;
   assign o_rise_tick = w_wrap & ~r_prog_clk;

endmodule

// File: rtl/prga_bitstream_streamer.sv
// PRGA bitstream streamer: takes bitstream words over valid/ready and
// shifts them MSB-first into the fabric scan chain on a divided clock.
//
// Handshake: a word transfers on any tb_clk edge where bs_valid && bs_ready.
// bs_ready is high only while waiting for a word (LOAD); bs_data/bs_last
// must be held stable while bs_valid is high and not yet accepted.
module prga_bitstream_streamer
   import prga_streamer_pkg::*;
#(
   parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
   parameter int CLK_DIV       = 2,
   parameter int RST_CYCLES    = 4,
   parameter int DONE_DELAY    = 8,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic                  tb_clk,
   input  logic                  tb_rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] bs_data,
   input  logic                  bs_valid,
   input  logic                  bs_last,
   output logic                  bs_ready,
   output logic                  prog_clk,
   output logic                  prog_rst,
   output logic                  prog_we,
   output logic                  prog_din,
   input  logic                  prog_dout,
   input  logic                  prog_we_o,
   output logic                  prog_done,
   output logic                  tb_prog_done,
   output logic                  err,
   output logic [31:0]           bits_sent,
   output logic [31:0]           echo_cnt,
   output state_e                o_dbg_state,
   output logic                  o_tail_dout
);

   localparam int BCW = bit_cnt_width(WORD_WIDTH);

   logic                  w_fall;
   logic                  w_rise;
   logic                  w_prog_clk;
   logic                  w_hs;

   state_e                r_state;
   logic                  r_start_pend;
   logic [WORD_WIDTH-1:0] r_shreg;
   logic [BCW-1:0]        r_bitcnt;
   logic                  r_last;
   logic [31:0]           r_stall;
   logic [31:0]           r_aux;
   logic                  r_prog_rst;
   logic                  r_prog_we;
   logic                  r_prog_din;
   logic                  r_prog_done;
   logic                  r_tb_done;
   logic                  r_err;
   logic [31:0]           r_bits_sent;
   logic [31:0]           r_echo_cnt;
   logic                  r_tail_dout;

   prga_prog_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .i_clk       (tb_clk),
      .i_rst       (tb_rst),
      .o_prog_clk  (w_prog_clk),
      .o_fall_tick (w_fall),
      .o_rise_tick (w_rise)
   );

   // The shift register is empty exactly while we sit in LOAD.
   assign bs_ready = (r_state == LOAD);
   assign w_hs     = bs_valid & bs_ready;

   // Sequencer: fabric-facing outputs change only on fall ticks so they are
   // settled at every prog_clk rise; word capture may happen on any edge.
   always_ff @(posedge tb_clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_state      <= IDLE;
         r_start_pend <= 1'b0;
         r_shreg      <= '0;
         r_bitcnt     <= '0;
         r_last       <= 1'b0;
         r_stall      <= '0;
         r_aux        <= '0;
         r_prog_rst   <= 1'b1;
         r_prog_we    <= 1'b0;
         r_prog_din   <= 1'b0;
         r_prog_done  <= 1'b0;
         r_tb_done    <= 1'b0;
         r_err        <= 1'b0;
         r_bits_sent  <= '0;
         r_echo_cnt   <= '0;
         r_tail_dout  <= 1'b0;
      end else begin
         // Chain-tail monitors, sampled where the fabric samples.
         if (w_rise) begin
            r_tail_dout <= prog_dout;
            if (prog_we_o && (r_state != IDLE)) begin
               r_echo_cnt <= sat_inc(r_echo_cnt);
            end
         end

         case (r_state)
            IDLE: begin
               r_prog_rst <= 1'b1;
               if (start) begin
                  r_start_pend <= 1'b1;
               end
               if (w_fall && (r_start_pend || start)) begin
                  r_start_pend <= 1'b0;
                  r_bits_sent  <= '0;
                  r_echo_cnt   <= '0;
                  r_err        <= 1'b0;
                  r_stall      <= '0;
                  r_aux        <= '0;
                  r_state      <= RST;
               end
            end

            RST: begin
               if (w_fall) begin
                  if (int'(r_aux) + 1 >= RST_CYCLES) begin
                     r_prog_rst <= 1'b0;
                     r_aux      <= '0;
                     r_state    <= LOAD;
                  end else begin
                     r_aux <= r_aux + 32'd1;
                  end
               end
            end

            LOAD: begin
               if (w_hs) begin
                  r_shreg  <= bs_data;
                  r_bitcnt <= BCW'(WORD_WIDTH);
                  r_last   <= bs_last;
                  r_state  <= SHIFT;
               end
               // A word arriving on the fall-tick edge itself still costs this
               // period, but it is not counted as starvation.
               if (w_fall) begin
                  r_prog_we <= 1'b0;
                  if (!w_hs) begin
                     if (int'(r_stall) + 1 >= STALL_TIMEOUT) begin
                        r_err       <= 1'b1;
                        r_prog_done <= 1'b0;
                        r_state     <= ERROR;
                     end else begin
                        r_stall <= r_stall + 32'd1;
                     end
                  end
               end
            end

            SHIFT: begin
               if (w_fall) begin
                  r_prog_we   <= 1'b1;
                  r_prog_din  <= r_shreg[WORD_WIDTH-1];
                  r_shreg     <= {r_shreg[WORD_WIDTH-2:0], 1'b0};
                  r_bits_sent <= sat_inc(r_bits_sent);
                  r_bitcnt    <= r_bitcnt - 1'b1;
                  r_stall     <= '0;
                  if (r_bitcnt == BCW'(1)) begin
                     r_state <= r_last ? FINISH : LOAD;
                  end
               end
            end

            FINISH: begin
               if (w_fall) begin
                  if (!r_prog_done) begin
                     r_prog_we   <= 1'b0;
                     r_prog_done <= 1'b1;
                     r_aux       <= '0;
                     if (DONE_DELAY == 0) begin
                        r_tb_done <= 1'b1;
                        r_state   <= DONE;
                     end
                  end else if (int'(r_aux) + 1 >= DONE_DELAY) begin
                     r_tb_done <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_aux <= r_aux + 32'd1;
                  end
               end
            end

            DONE: begin
               r_prog_we <= 1'b0;
            end

            ERROR: begin
               r_prog_we   <= 1'b0;
               r_err       <= 1'b1;
               r_prog_done <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign prog_clk     = w_prog_clk;
   assign prog_rst     = r_prog_rst;
   assign prog_we      = r_prog_we;
   assign prog_din     = r_prog_din;
   assign prog_done    = r_prog_done;
   assign tb_prog_done = r_tb_done;
   assign err          = r_err;
   assign bits_sent    = r_bits_sent;
   assign echo_cnt     = r_echo_cnt;
   assign o_dbg_state  = r_state;
   assign o_tail_dout  = r_tail_dout;

endmodule

// File: tb/tb_prga_bitstream_streamer.sv
// Directed bench for prga_bitstream_streamer (WORD_WIDTH=32, CLK_DIV=2,
// RST_CYCLES=4, DONE_DELAY=8, STALL_TIMEOUT=16).
module tb_prga_bitstream_streamer;
   import prga_streamer_pkg::*;

   localparam int WW = 32;

   // ---------------- clock / reset / DUT ----------------
   logic          tb_clk = 1'b0;
   logic          tb_rst = 1'b1;
   logic          start = 1'b0;
   logic [WW-1:0] bs_data = '0;
   logic          bs_valid = 1'b0;
   logic          bs_last = 1'b0;
   logic          prog_dout = 1'b0;
   logic          prog_we_o = 1'b0;
   logic          bs_ready, prog_clk, prog_rst, prog_we, prog_din;
   logic          prog_done, tb_prog_done, err, tail_dout;
   logic [31:0]   bits_sent, echo_cnt;
   state_e        dbg_state;

   always #5 tb_clk = ~tb_clk;

   prga_bitstream_streamer #(
      .WORD_WIDTH    (WW),
      .CLK_DIV       (2),
      .RST_CYCLES    (4),
      .DONE_DELAY    (8),
      .STALL_TIMEOUT (16)
   ) dut (
      .tb_clk       (tb_clk),
      .tb_rst       (tb_rst),
      .start        (start),
      .bs_data      (bs_data),
      .bs_valid     (bs_valid),
      .bs_last      (bs_last),
      .bs_ready     (bs_ready),
      .prog_clk     (prog_clk),
      .prog_rst     (prog_rst),
      .prog_we      (prog_we),
      .prog_din     (prog_din),
      .prog_dout    (prog_dout),
      .prog_we_o    (prog_we_o),
      .prog_done    (prog_done),
      .tb_prog_done (tb_prog_done),
      .err          (err),
      .bits_sent    (bits_sent),
      .echo_cnt     (echo_cnt),
      .o_dbg_state  (dbg_state),
      .o_tail_dout  (tail_dout)
   );

   int checks = 0;
   int errors = 0;

   // Fabric chain-tail model: prog_we comes back 4 prog_clk periods later;
   // the chain is cleared while the fabric is held in reset.
   logic [4:0] tail_dly = '0;
   always @(negedge prog_clk) begin
      #1;
      if (prog_rst) tail_dly = '0;
      else          tail_dly = {tail_dly[3:0], prog_we};
      prog_we_o = tail_dly[4];
      prog_dout = tail_dly[4];
   end

   // Per-rise log of fabric-facing outputs: {prog_rst, tb_done, done, din, we}.
   logic [4:0] rise_log[$];
   bit         log_en = 1'b0;
   always @(posedge prog_clk) begin
      #1;
      if (log_en) rise_log.push_back({prog_rst, tb_prog_done, prog_done, prog_din, prog_we});
   end

   // Scoreboard: expected serial bits in shift order.
   logic [0:0]    exp_q[$];
   logic [WW-1:0] w_data[4];
   logic          w_last[4];
   int            w_gap[4];

   // ---------------- observation helpers ----------------
   function automatic int count_we();
      int n = 0;
      foreach (rise_log[i]) if (rise_log[i][0]) n++;
      return n;
   endfunction

   function automatic int first_idx(input int b);
      foreach (rise_log[i]) if (rise_log[i][b]) return i;
      return -1;
   endfunction

   function automatic int last_idx(input int b);
      int r = -1;
      foreach (rise_log[i]) if (rise_log[i][b]) r = i;
      return r;
   endfunction

   function automatic int gap_lows();
      int n = 0;
      int f = first_idx(0);
      int l = last_idx(0);
      if (f < 0) return -1;
      for (int i = f; i <= l; i++) if (!rise_log[i][0]) n++;
      return n;
   endfunction

   function automatic int stream_bad();
      int k = 0;
      int bad = 0;
      foreach (rise_log[i]) begin
         if (rise_log[i][0]) begin
            if (k >= exp_q.size() || rise_log[i][1] !== exp_q[k][0]) bad++;
            k++;
         end
      end
      if (k != exp_q.size()) bad++;
      return bad;
   endfunction

   function automatic logic [7:0] first_byte();
      logic [7:0] v = '0;
      int k = 0;
      foreach (rise_log[i]) begin
         if (rise_log[i][0] && k < 8) begin
            v[7-k] = rise_log[i][1];
            k++;
         end
      end
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic assert_reset();
      tb_rst = 1'b1;
      start = 1'b0;
      bs_valid = 1'b0;
      bs_last = 1'b0;
      log_en = 1'b0;
      repeat (3) @(negedge tb_clk);
   endtask

   task automatic release_reset();
      tb_rst = 1'b0;
      repeat (2) @(negedge tb_clk);
   endtask

   task automatic pulse_start();
      @(negedge tb_clk);
      start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
   endtask

   task automatic build_exp(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++)
         for (int b = WW - 1; b >= 0; b--) exp_q.push_back(w_data[i][b]);
   endtask

   task automatic feed_words(input int n);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         if (w_gap[i] > 0) begin
            while (!bs_ready && t < 2000) begin @(negedge tb_clk); t++; end
            repeat (w_gap[i]) @(negedge prog_clk);
            #1;
         end
         bs_data = w_data[i];
         bs_last = w_last[i];
         bs_valid = 1'b1;
         t = 0;
         do begin @(negedge tb_clk); t++; end while (!bs_ready && t < 2000);
         if (!bs_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_handshake word %0d: bs_ready=%b after %0d cycles, want 1", i, bs_ready, t);
            bs_valid = 1'b0;
            return;
         end
         @(posedge tb_clk);
         #1;
         bs_valid = 1'b0;
         bs_last = 1'b0;
      end
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < 4000 && !tb_prog_done && !err) begin @(negedge tb_clk); n++; end
      if (tb_prog_done) begin
         @(posedge prog_clk);
         #2;
         ok = 1'b1;
      end
   endtask

   task automatic run_stream(input int n, output bit ok);
      rise_log.delete();
      log_en = 1'b1;
      build_exp(n);
      fork
         feed_words(n);
         pulse_start();
      join
      wait_done(ok);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      assert_reset();
      checks++; if (prog_clk !== 1'b0) begin errors++; $display("FAIL reset_prog_clk got %b want 0", prog_clk); end
      checks++; if (prog_rst !== 1'b1) begin errors++; $display("FAIL reset_prog_rst got %b want 1", prog_rst); end
      checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL reset_prog_we got %b want 0", prog_we); end
      checks++; if (prog_din !== 1'b0) begin errors++; $display("FAIL reset_prog_din got %b want 0", prog_din); end
      checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_prog_done got %b want 0", prog_done); end
      checks++; if (tb_prog_done !== 1'b0) begin errors++; $display("FAIL reset_tb_prog_done got %b want 0", tb_prog_done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (bs_ready !== 1'b0) begin errors++; $display("FAIL reset_bs_ready got %b want 0", bs_ready); end
      checks++; if (bits_sent !== 32'd0) begin errors++; $display("FAIL reset_bits_sent got %0d want 0", bits_sent); end
      checks++; if (echo_cnt !== 32'd0) begin errors++; $display("FAIL reset_echo_cnt got %0d want 0", echo_cnt); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
      release_reset();
      repeat (10) @(negedge tb_clk);
      checks++; if (prog_rst !== 1'b1) begin errors++; $display("FAIL idle_prog_rst got %b want 1", prog_rst); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL idle_state got %0d want IDLE", dbg_state); end
   endtask

   task automatic test_single_word();
      bit ok;
      int lw, pd, td;
      assert_reset();
      release_reset();
      w_data[0] = 32'hA500_0001; w_last[0] = 1'b1; w_gap[0] = 0;
      run_stream(1, ok);
      lw = last_idx(0); pd = first_idx(2); td = first_idx(3);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", ok); end
      checks++; if (first_byte() !== 8'hA5) begin errors++; $display("FAIL single_first_byte got %h want a5", first_byte()); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL single_stream bad=%0d want 0", stream_bad()); end
      checks++; if (count_we() != 32) begin errors++; $display("FAIL single_we_periods got %0d want 32", count_we()); end
      checks++; if (gap_lows() != 0) begin errors++; $display("FAIL single_we_gaps got %0d want 0", gap_lows()); end
      checks++; if (bits_sent !== 32'd32) begin errors++; $display("FAIL single_bits_sent got %0d want 32", bits_sent); end
      checks++; if (pd - lw != 1) begin errors++; $display("FAIL single_done_delay got %0d want 1", pd - lw); end
      checks++; if (td - pd != 8) begin errors++; $display("FAIL single_tb_done_delay got %0d want 8", td - pd); end
      checks++; if (echo_cnt !== 32'd32) begin errors++; $display("FAIL single_echo got %0d want 32", echo_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
      checks++; if (prog_rst !== 1'b0) begin errors++; $display("FAIL single_prog_rst got %b want 0", prog_rst); end
      checks++; if (dbg_state !== DONE) begin errors++; $display("FAIL single_state got %0d want DONE", dbg_state); end
   endtask

   task automatic test_gap();
      bit ok;
      assert_reset();
      release_reset();
      w_data[0] = 32'h1234_5678; w_last[0] = 1'b0; w_gap[0] = 0;
      w_data[1] = 32'hDEAD_BEEF; w_last[1] = 1'b0; w_gap[1] = 5;
      w_data[2] = 32'h0F0F_00FF; w_last[2] = 1'b1; w_gap[2] = 0;
      run_stream(3, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_done got %b want 1", ok); end
      checks++; if (gap_lows() != 5) begin errors++; $display("FAIL gap_low_periods got %0d want 5", gap_lows()); end
      checks++; if (count_we() != 96) begin errors++; $display("FAIL gap_we_periods got %0d want 96", count_we()); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL gap_stream bad=%0d want 0", stream_bad()); end
      checks++; if (bits_sent !== 32'd96) begin errors++; $display("FAIL gap_bits_sent got %0d want 96", bits_sent); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL gap_err got %b want 0", err); end
   endtask

   task automatic test_stall();
      int n = 0;
      assert_reset();
      release_reset();
      rise_log.delete();
      log_en = 1'b1;
      pulse_start();
      while (prog_rst && n < 200) begin @(negedge tb_clk); n++; end
      n = 0;
      while (n < 100) begin
         @(negedge prog_clk);
         #1;
         n++;
         if (err) break;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL stall_periods got %0d want 16", n); end
      repeat (20) @(negedge tb_clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_err got %b want 1", err); end
      checks++; if (count_we() != 0) begin errors++; $display("FAIL stall_we_periods got %0d want 0", count_we()); end
      checks++; if (tb_prog_done !== 1'b0) begin errors++; $display("FAIL stall_tb_done got %b want 0", tb_prog_done); end
      checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL stall_prog_done got %b want 0", prog_done); end
      checks++; if (dbg_state !== ERROR) begin errors++; $display("FAIL stall_state got %0d want ERROR", dbg_state); end
      checks++; if (bits_sent !== 32'd0) begin errors++; $display("FAIL stall_bits_sent got %0d want 0", bits_sent); end
   endtask

   task automatic test_start_ignored();
      bit ok;
      int sent_at_start = 0;
      assert_reset();
      release_reset();
      w_data[0] = 32'h3C96_A50F; w_last[0] = 1'b1; w_gap[0] = 0;
      fork
         run_stream(1, ok);
         begin
            int t = 0;
            while (bits_sent < 10 && t < 2000) begin @(negedge tb_clk); t++; end
            sent_at_start = int'(bits_sent);
            pulse_start();
         end
      join
      checks++; if (sent_at_start < 10 || sent_at_start >= 32) begin errors++; $display("FAIL ign_start_timing got %0d want 10..31", sent_at_start); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", ok); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL ign_stream bad=%0d want 0", stream_bad()); end
      checks++; if (bits_sent !== 32'd32) begin errors++; $display("FAIL ign_bits_sent got %0d want 32", bits_sent); end
      pulse_start();
      bs_data = 32'hFFFF_FFFF;
      bs_valid = 1'b1;
      repeat (40) @(negedge tb_clk);
      checks++; if (bs_ready !== 1'b0) begin errors++; $display("FAIL ign_ready_after_last got %b want 0", bs_ready); end
      bs_valid = 1'b0;
      checks++; if (dbg_state !== DONE) begin errors++; $display("FAIL ign_state got %0d want DONE", dbg_state); end
      checks++; if (bits_sent !== 32'd32) begin errors++; $display("FAIL ign_bits_after got %0d want 32", bits_sent); end
      checks++; if (echo_cnt !== 32'd32) begin errors++; $display("FAIL ign_echo got %0d want 32", echo_cnt); end
      checks++; if (tb_prog_done !== 1'b1) begin errors++; $display("FAIL ign_tb_done got %b want 1", tb_prog_done); end
      checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL ign_prog_done got %b want 1", prog_done); end
      checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL ign_prog_we got %b want 0", prog_we); end
      checks++; if (prog_rst !== 1'b0) begin errors++; $display("FAIL ign_prog_rst got %b want 0", prog_rst); end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int t = 0;
      assert_reset();
      release_reset();
      bs_data = 32'hFFFF_FFFF;
      bs_last = 1'b0;
      bs_valid = 1'b1;
      pulse_start();
      while (bits_sent < 10 && t < 2000) begin @(negedge tb_clk); t++; end
      checks++; if (prog_we !== 1'b1) begin errors++; $display("FAIL mid_we_before got %b want 1", prog_we); end
      @(posedge tb_clk);
      #1;
      tb_rst = 1'b1;
      bs_valid = 1'b0;
      #1;
      checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b want 0", prog_we); end
      checks++; if (prog_rst !== 1'b1) begin errors++; $display("FAIL mid_rst_prog_rst got %b want 1", prog_rst); end
      checks++; if (bits_sent !== 32'd0) begin errors++; $display("FAIL mid_rst_bits got %0d want 0", bits_sent); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d want IDLE", dbg_state); end
      repeat (2) @(negedge tb_clk);
      release_reset();
      w_data[0] = 32'h5A5A_C3C3; w_last[0] = 1'b1; w_gap[0] = 0;
      run_stream(1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_redo_done got %b want 1", ok); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL mid_redo_stream bad=%0d want 0", stream_bad()); end
      checks++; if (bits_sent !== 32'd32) begin errors++; $display("FAIL mid_redo_bits got %0d want 32", bits_sent); end
      checks++; if (echo_cnt !== 32'd32) begin errors++; $display("FAIL mid_redo_echo got %0d want 32", echo_cnt); end
   endtask

   task automatic test_loopback();
      bit ok;
      assert_reset();
      release_reset();
      w_data[0] = 32'h8000_0001; w_last[0] = 1'b0; w_gap[0] = 0;
      w_data[1] = 32'hFFFF_0000; w_last[1] = 1'b1; w_gap[1] = 0;
      run_stream(2, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_done got %b want 1", ok); end
      checks++; if (echo_cnt !== 32'd64) begin errors++; $display("FAIL loop_echo got %0d want 64", echo_cnt); end
      checks++; if (bits_sent !== 32'd64) begin errors++; $display("FAIL loop_bits got %0d want 64", bits_sent); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL loop_stream bad=%0d want 0", stream_bad()); end
      checks++; if (gap_lows() != 0) begin errors++; $display("FAIL loop_we_gaps got %0d want 0", gap_lows()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_word();
      test_gap();
      test_stall();
      test_start_ignored();
      test_reset_mid_word();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/prga_bitstream_streamer.md
Name: prga_bitstream_streamer

Overview:
Synthesizable bitstream source that feeds the PRGA fabric's serial programming interface through the Caravel mprj_io pins (prog_clk/prog_rst/prog_we/prog_din/prog_done).
Accepts bitstream words over a valid/ready stream from a memory or FIFO. Generates a divided programming clock, a programming reset, and an MSB-first serial shift with stall support.
Signals completion to the testbench control logic through tb_prog_done. Sits directly upstream of the fabric's scan-chain programming port.

Parameters:
WORD_WIDTH, 32, bitstream word width; power of two, >= 8
CLK_DIV, 2, tb_clk cycles per prog_clk half-period; >= 1
RST_CYCLES, 4, prog_clk periods prog_rst is held high after start
DONE_DELAY, 8, prog_clk periods between prog_done rising and tb_prog_done rising
STALL_TIMEOUT, 1024, max consecutive starved prog_clk periods before error

Ports:
tb_clk  in  1  system clock
tb_rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, begins programming; honoured only in IDLE
bs_data  in  WORD_WIDTH  bitstream word, bit WORD_WIDTH-1 is shifted first
bs_valid  in  1  bs_data valid
bs_last  in  1  qualifies the final word of the bitstream
bs_ready  out  1  word accepted when bs_valid && bs_ready at a tb_clk edge
prog_clk  out  1  programming clock, 50% duty, period 2*CLK_DIV tb_clk cycles
prog_rst  out  1  programming reset to fabric
prog_we  out  1  shift enable to fabric
prog_din  out  1  serial data to fabric
prog_dout  in  1  serial data from chain tail
prog_we_o  in  1  shift enable from chain tail
prog_done  out  1  programming complete to fabric
tb_prog_done  out  1  completion flag to testbench control
err  out  1  sticky stall-timeout error
bits_sent  out  32  count of bits shifted with prog_we=1
echo_cnt  out  32  count of prog_clk rising edges sampling prog_we_o=1

Behaviour:
- Reset values:
  - prog_clk=0, prog_rst=1, prog_we=0, prog_din=0, prog_done=0, tb_prog_done=0, err=0, bs_ready=0, bits_sent=0, echo_cnt=0.
  - State=IDLE.
- Divider:
  - Counter 0..CLK_DIV-1 runs in all states.
  - prog_clk toggles on wrap.
  - "Fall tick" is the tb_clk edge on which prog_clk goes 1->0. "Rise tick" is the edge on which it goes 0->1.
  - prog_rst, prog_we, prog_din and prog_done update only on fall ticks, so they are stable at every prog_clk rise.
- FSM, transitions on fall ticks unless noted:
  - IDLE: prog_rst=1. On start (sampled on any tb_clk edge, latched until the next fall tick): clear bits_sent, echo_cnt and err; go to RST.
  - RST: prog_rst=1 for RST_CYCLES fall ticks, then drive prog_rst=0 and go to LOAD.
  - LOAD:
    - bs_ready=1 combinationally while in LOAD with the shift register empty.
    - On handshake, capture the word and bs_last into shift register, bit counter=WORD_WIDTH and last flag; go to SHIFT.
    - If no word arrives by a fall tick: prog_we=0 and the stall counter increments.
    - Stall counter reaching STALL_TIMEOUT -> ERROR.
  - SHIFT:
    - Each fall tick: prog_we=1, prog_din=shreg MSB, shift left, bits_sent+1, counter-1.
    - When the counter reaches 0 after the fall tick that emits the last bit: if the last flag is set go to FINISH, else go to LOAD.
    - The stall counter clears on every emitted bit.
  - FINISH: next fall tick drives prog_we=0, prog_done=1. Wait DONE_DELAY fall ticks, then tb_prog_done=1 and go to DONE.
  - DONE: outputs hold. start is ignored. Only tb_rst leaves this state.
  - ERROR: prog_we=0, err=1, prog_done=0. Holds until tb_rst.
- Interface rules:
  - start outside IDLE is ignored.
  - A word whose bs_last=1 is the final word; bs_valid afterwards is never accepted (bs_ready=0).
  - A gap between words deasserts prog_we for whole prog_clk periods only; no partial-period pulses.
- echo_cnt increments on rise ticks when prog_we_o=1, in any state except IDLE.
- tb_rst asserted mid-operation aborts immediately to reset values; the fabric sees prog_rst=1.
- Counters saturate at 2^32-1.

Decomposition:
- Package prga_streamer_pkg: state enum (IDLE, RST, LOAD, SHIFT, FINISH, DONE, ERROR) and the localparam width of the bit counter, $clog2(WORD_WIDTH)+1.
- One sub-module, prga_prog_clkdiv: the divider producing prog_clk, fall_tick and rise_tick.

Test Plan:
- WORD_WIDTH=32, CLK_DIV=2: send one word 0xA5000001 with bs_last=1 -> prog_din samples at prog_clk rises are 1,0,1,0,0,1,0,1, then 0x000001 MSB-first; prog_we high exactly 32 periods; bits_sent=32; prog_done rises 1 period later; tb_prog_done rises 8 periods after that.
- Three words, bs_valid low for 5 prog_clk periods before word 2 -> prog_we low exactly 5 full periods; bits_sent=96; no err.
- bs_valid never asserted after start, STALL_TIMEOUT=16 -> err=1 after 16 starved periods; prog_we stays 0; tb_prog_done stays 0.
- start pulsed again during SHIFT and in DONE -> no effect on state, counters or outputs.
- tb_rst asserted mid-word (bit 10 of word 1) -> same tb_clk edge: prog_we=0, prog_rst=1, bits_sent=0, state IDLE. A new start then reprograms correctly.
- Loop prog_we_o to prog_we delayed by 4 prog_clk periods, 64-bit stream -> echo_cnt=64 by tb_prog_done.
